// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared memop encoding, request and tag types for the memory port arbiter.
package mem_arb_pkg;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_MASK_W = MAX_DATA_W / 8;
  localparam int PORT_W = 3;
  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STORE   = 2'd2,
    OP_ILLEGAL = 2'd3
  } memop_e;
  typedef struct packed {
    memop_e                op;
    logic [MAX_MASK_W-1:0] mask;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } mem_req_t;
  // load rides along so the exit stage knows whether ram_resp is meaningful
  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] port;
    logic              err;
    logic              load;
  } tag_t;
  function automatic logic is_ram_op(memop_e op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side handshake bundle plus RAM-side request/response fields.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
);
  localparam int MASK_W = DATA_W / 8;
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [2*NUM_PORTS-1:0]      req_op;
  logic [ADDR_W*NUM_PORTS-1:0] req_addr;
  logic [DATA_W*NUM_PORTS-1:0] req_data;
  logic [MASK_W*NUM_PORTS-1:0] req_mask;
  logic [NUM_PORTS-1:0]        resp_valid;
  logic [NUM_PORTS-1:0]        resp_err;
  logic [DATA_W-1:0]           resp_data;
  logic                        ram_enable;
  logic [1:0]                  ram_op;
  logic [ADDR_W-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_data;
  logic [MASK_W-1:0]           ram_mask;
  logic                        ram_busy;
  logic [DATA_W-1:0]           ram_resp;
  modport master (
    output req_valid, req_op, req_addr, req_data, req_mask, ram_busy, ram_resp,
    input  req_ready, resp_valid, resp_err, resp_data, ram_enable, ram_op, ram_addr, ram_data, ram_mask
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_mask, ram_busy, ram_resp,
    output req_ready, resp_valid, resp_err, resp_data, ram_enable, ram_op, ram_addr, ram_data, ram_mask
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requesting port at or after ptr.
module rr_arbiter #(
  parameter int  N  = 2,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [N-1:0] rot, first;
  // rotate so ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = rot & (~rot + N'(1));
    grant = N'(({first, first} << ptr) >> N);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-port front end to a single fixed-latency RAM,
// with zero-cycle issue and a RAM_LAT-deep tag pipe routing responses home.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int RAM_LAT   = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  logic [PTR_W-1:0]     ptr_q, ptr_d, gidx;
  logic [NUM_PORTS-1:0] grant, ready;
  logic                 accept;
  mem_req_t             sel;
  tag_t                 tag_q [RAM_LAT];
  tag_t                 tag_d [RAM_LAT];
  tag_t                 tag_out;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req  (bus.req_valid),
    .ptr  (ptr_q),
    .grant(grant)
  );

  // ready is held low during reset so nothing is accepted while state is cleared
  assign ready         = grant & {NUM_PORTS{~bus.ram_busy & rst_n}};
  assign accept        = |ready;
  assign bus.req_ready = ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (grant[i]) gidx = PTR_W'(i);
  end

  always_comb begin
    sel.op   = memop_e'(bus.req_op[int'(gidx)*2 +: 2]);
    sel.mask = MAX_MASK_W'(bus.req_mask[int'(gidx)*MASK_W +: MASK_W]);
    sel.addr = MAX_ADDR_W'(bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W]);
    sel.data = MAX_DATA_W'(bus.req_data[int'(gidx)*DATA_W +: DATA_W]);
  end

  assign bus.ram_enable = accept & is_ram_op(sel.op);
  assign bus.ram_op     = sel.op;
  assign bus.ram_addr   = sel.addr[ADDR_W-1:0];
  assign bus.ram_data   = sel.data[DATA_W-1:0];
  assign bus.ram_mask   = sel.mask[MASK_W-1:0];

  always_comb begin
    ptr_d = !accept ? ptr_q : (int'(gidx) == NUM_PORTS - 1) ? '0 : gidx + PTR_W'(1);
    tag_d[0].valid = accept;
    tag_d[0].port  = PORT_W'(gidx);
    tag_d[0].err   = accept && sel.op == OP_ILLEGAL;
    tag_d[0].load  = accept && sel.op == OP_LOAD;
    for (int i = 1; i < RAM_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

  assign tag_out        = tag_q[RAM_LAT-1];
  assign bus.resp_valid = NUM_PORTS'(tag_out.valid) << tag_out.port;
  assign bus.resp_err   = NUM_PORTS'(tag_out.valid & tag_out.err) << tag_out.port;
  assign bus.resp_data  = (tag_out.valid & tag_out.load) ? bus.ram_resp : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios on a RAM_LAT=1 and a RAM_LAT=3 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64)) b1 ();
  mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64)) b3 ();

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .RAM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .RAM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv1(input int p, input logic v, input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data);
    b1.req_valid[p] = v;
    b1.req_op[2*p +: 2] = op;
    b1.req_addr[64*p +: 64] = addr;
    b1.req_data[64*p +: 64] = data;
    b1.req_mask[8*p +: 8] = 8'hFF;
  endtask

  task automatic drv3(input int p, input logic v, input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data);
    b3.req_valid[p] = v;
    b3.req_op[2*p +: 2] = op;
    b3.req_addr[64*p +: 64] = addr;
    b3.req_data[64*p +: 64] = data;
    b3.req_mask[8*p +: 8] = 8'hFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv1(0, 1, 2'd1, 64'h10, 0); drv1(1, 1, 2'd1, 64'h20, 0);
    drv3(0, 1, 2'd1, 64'h10, 0); drv3(1, 1, 2'd1, 64'h20, 0);
    #1;
    checks++; if (b1.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", b1.req_ready); end
    checks++; if (b1.ram_enable !== 1'b0) begin errors++; $display("FAIL rst_ram_enable got %b exp 0", b1.ram_enable); end
    checks++; if (b1.resp_valid !== 2'b00 || b1.resp_err !== 2'b00) begin errors++; $display("FAIL rst_resp got %b/%b exp 00/00", b1.resp_valid, b1.resp_err); end
    checks++; if (b3.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready3 got %b exp 00", b3.req_ready); end
    drv1(0, 0, 0, 0, 0); drv1(1, 0, 0, 0, 0); drv3(0, 0, 0, 0, 0); drv3(1, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    drv1(1, 1, 2'd1, 64'h100, 0);
    #1;
    checks++; if (b1.req_ready !== 2'b10) begin errors++; $display("FAIL load_ready got %b exp 10", b1.req_ready); end
    checks++; if (b1.ram_enable !== 1'b1 || b1.ram_op !== 2'd1 || b1.ram_addr !== 64'h100) begin errors++; $display("FAIL load_issue got en=%b op=%0d addr=%h exp en=1 op=1 addr=100", b1.ram_enable, b1.ram_op, b1.ram_addr); end
    checks++; if (b1.resp_data !== 64'h0) begin errors++; $display("FAIL post_reset_data got %h exp 0", b1.resp_data); end
    step();
    drv1(1, 0, 0, 0, 0);
    #1;
    checks++; if (b1.resp_valid !== 2'b10 || b1.resp_err !== 2'b00) begin errors++; $display("FAIL load_resp got %b/%b exp 10/00", b1.resp_valid, b1.resp_err); end
    checks++; if (b1.resp_data !== 64'hDEADBEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", b1.resp_data); end
    step();
    #1;
    checks++; if (b1.resp_valid !== 2'b00 || b1.resp_data !== 64'h0) begin errors++; $display("FAIL load_pulse got %b/%h exp 00/0", b1.resp_valid, b1.resp_data); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp, prev;
    prev = 2'b00;
    drv1(0, 1, 2'd1, 64'h10, 0); drv1(1, 1, 2'd1, 64'h20, 0);
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      checks++; if (b1.req_ready !== exp || b1.ram_addr !== (exp == 2'b01 ? 64'h10 : 64'h20)) begin errors++; $display("FAIL rr_grant%0d got %b/%h exp %b", i, b1.req_ready, b1.ram_addr, exp); end
      checks++; if (b1.resp_valid !== prev) begin errors++; $display("FAIL rr_resp%0d got %b exp %b", i, b1.resp_valid, prev); end
      prev = exp;
      step();
    end
    drv1(0, 0, 0, 0, 0); drv1(1, 0, 0, 0, 0);
    #1;
    checks++; if (b1.resp_valid !== 2'b10) begin errors++; $display("FAIL rr_last_resp got %b exp 10", b1.resp_valid); end
    step();
  endtask

  task automatic test_busy();
    drv1(0, 1, 2'd1, 64'h30, 0); drv1(1, 1, 2'd1, 64'h38, 0);
    #1;
    checks++; if (b1.req_ready !== 2'b01) begin errors++; $display("FAIL busy_pre got %b exp 01", b1.req_ready); end
    step();
    b1.ram_busy = 1'b1;
    #1;
    checks++; if (b1.req_ready !== 2'b00 || b1.ram_enable !== 1'b0) begin errors++; $display("FAIL busy1 got %b/%b exp 00/0", b1.req_ready, b1.ram_enable); end
    checks++; if (b1.resp_valid !== 2'b01) begin errors++; $display("FAIL busy_inflight got %b exp 01", b1.resp_valid); end
    step();
    #1;
    checks++; if (b1.req_ready !== 2'b00 || b1.resp_valid !== 2'b00) begin errors++; $display("FAIL busy2 got %b/%b exp 00/00", b1.req_ready, b1.resp_valid); end
    step();
    b1.ram_busy = 1'b0;
    #1;
    checks++; if (b1.req_ready !== 2'b10) begin errors++; $display("FAIL busy_ptr_hold got %b exp 10", b1.req_ready); end
    step();
    drv1(0, 0, 0, 0, 0); drv1(1, 0, 0, 0, 0);
    #1;
    checks++; if (b1.resp_valid !== 2'b10) begin errors++; $display("FAIL busy_post_resp got %b exp 10", b1.resp_valid); end
    step();
  endtask

  task automatic test_illegal_nop();
    drv1(0, 1, 2'd3, 64'h50, 0);
    #1;
    checks++; if (b1.req_ready !== 2'b01 || b1.ram_enable !== 1'b0) begin errors++; $display("FAIL ill_issue got %b/%b exp 01/0", b1.req_ready, b1.ram_enable); end
    step();
    drv1(0, 0, 0, 0, 0);
    drv1(1, 1, 2'd0, 64'h58, 0);
    #1;
    checks++; if (b1.resp_valid !== 2'b01 || b1.resp_err !== 2'b01 || b1.resp_data !== 64'h0) begin errors++; $display("FAIL ill_resp got %b/%b/%h exp 01/01/0", b1.resp_valid, b1.resp_err, b1.resp_data); end
    checks++; if (b1.req_ready !== 2'b10 || b1.ram_enable !== 1'b0) begin errors++; $display("FAIL nop_issue got %b/%b exp 10/0", b1.req_ready, b1.ram_enable); end
    step();
    drv1(1, 0, 0, 0, 0);
    #1;
    checks++; if (b1.resp_valid !== 2'b10 || b1.resp_err !== 2'b00 || b1.resp_data !== 64'h0) begin errors++; $display("FAIL nop_resp got %b/%b/%h exp 10/00/0", b1.resp_valid, b1.resp_err, b1.resp_data); end
    step();
  endtask

  task automatic test_lat3();
    drv3(0, 1, 2'd2, 64'h40, 64'hAA);
    #1;
    checks++; if (b3.req_ready !== 2'b01 || b3.ram_enable !== 1'b1 || b3.ram_op !== 2'd2) begin errors++; $display("FAIL l3_store got %b/%b/%0d exp 01/1/2", b3.req_ready, b3.ram_enable, b3.ram_op); end
    checks++; if (b3.ram_data !== 64'hAA || b3.ram_mask !== 8'hFF || b3.ram_addr !== 64'h40) begin errors++; $display("FAIL l3_fields got %h/%h/%h exp aa/ff/40", b3.ram_data, b3.ram_mask, b3.ram_addr); end
    step();
    drv3(0, 0, 0, 0, 0); drv3(1, 1, 2'd1, 64'h80, 0);
    #1;
    checks++; if (b3.req_ready !== 2'b10 || b3.ram_enable !== 1'b1 || b3.resp_valid !== 2'b00) begin errors++; $display("FAIL l3_load got %b/%b/%b exp 10/1/00", b3.req_ready, b3.ram_enable, b3.resp_valid); end
    step();
    drv3(1, 0, 0, 0, 0);
    #1;
    checks++; if (b3.resp_valid !== 2'b00) begin errors++; $display("FAIL l3_early got %b exp 00", b3.resp_valid); end
    step();
    #1;
    checks++; if (b3.resp_valid !== 2'b01 || b3.resp_data !== 64'h0) begin errors++; $display("FAIL l3_store_resp got %b/%h exp 01/0", b3.resp_valid, b3.resp_data); end
    step();
    #1;
    checks++; if (b3.resp_valid !== 2'b10 || b3.resp_data !== 64'hCAFEF00D) begin errors++; $display("FAIL l3_load_resp got %b/%h exp 10/cafef00d", b3.resp_valid, b3.resp_data); end
    step();
    #1;
    checks++; if (b3.resp_valid !== 2'b00) begin errors++; $display("FAIL l3_tail got %b exp 00", b3.resp_valid); end
  endtask

  task automatic test_reset_inflight();
    step();
    drv3(0, 1, 2'd1, 64'h90, 0);
    #1;
    checks++; if (b3.req_ready !== 2'b01) begin errors++; $display("FAIL ri_acc0 got %b exp 01", b3.req_ready); end
    step();
    #1;
    checks++; if (b3.req_ready !== 2'b01) begin errors++; $display("FAIL ri_acc1 got %b exp 01", b3.req_ready); end
    step();
    drv3(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (b3.req_ready !== 2'b00 || b3.resp_valid !== 2'b00) begin errors++; $display("FAIL ri_in_reset got %b/%b exp 00/00", b3.req_ready, b3.resp_valid); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b3.resp_valid !== 2'b00) begin errors++; $display("FAIL ri_drop%0d got %b exp 00", i, b3.resp_valid); end
      step();
    end
    drv3(0, 1, 2'd1, 64'hA0, 0); drv3(1, 1, 2'd1, 64'hA8, 0);
    #1;
    checks++; if (b3.req_ready !== 2'b01) begin errors++; $display("FAIL ri_ptr_reset got %b exp 01", b3.req_ready); end
    step();
    drv3(0, 0, 0, 0, 0); drv3(1, 0, 0, 0, 0);
    step();
    step();
    #1;
    checks++; if (b3.resp_valid !== 2'b01 || b3.resp_data !== 64'hCAFEF00D) begin errors++; $display("FAIL ri_after got %b/%h exp 01/cafef00d", b3.resp_valid, b3.resp_data); end
  endtask

  initial begin
    b1.req_valid = '0; b1.req_op = '0; b1.req_addr = '0; b1.req_data = '0; b1.req_mask = '0;
    b3.req_valid = '0; b3.req_op = '0; b3.req_addr = '0; b3.req_data = '0; b3.req_mask = '0;
    b1.ram_busy = 1'b0; b1.ram_resp = 64'hDEADBEEF;
    b3.ram_busy = 1'b0; b3.ram_resp = 64'hCAFEF00D;
    step();
    test_reset();
    test_single_load();
    test_round_robin();
    test_busy();
    test_illegal_nop();
    test_lat3();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesters (port 0 = instruction fetch, port 1 = data); legal range 1..8.
REQ-002 Parameter ADDR_W, default 64: address width.
REQ-003 Parameter DATA_W, default 64: data width; MASK_W = DATA_W/8.
REQ-004 Parameter RAM_LAT, default 1: fixed RAM read/ack latency in cycles; legal range 1..4.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_PORTS  per-port request valid.
REQ-008 req_ready  out  NUM_PORTS  per-port request accepted this cycle.
REQ-009 req_op  in  2*NUM_PORTS  per-port memop: 0 NOP, 1 LOAD, 2 STORE, 3 illegal.
REQ-010 req_addr  in  ADDR_W*NUM_PORTS  per-port address.
REQ-011 req_data  in  DATA_W*NUM_PORTS  per-port store data.
REQ-012 req_mask  in  MASK_W*NUM_PORTS  per-port byte mask.
REQ-013 resp_valid  out  NUM_PORTS  one-cycle response pulse to originating port.
REQ-014 resp_err  out  NUM_PORTS  response is an error (illegal op), qualified by resp_valid.
REQ-015 resp_data  out  DATA_W  shared response data, valid where resp_valid is set.
REQ-016 ram_enable  out  1  RAM access strobe.
REQ-017 ram_op, ram_addr, ram_data, ram_mask  out  2/ADDR_W/DATA_W/MASK_W  RAM request fields.
REQ-018 ram_busy  in  1  RAM cannot accept a request this cycle.
REQ-019 ram_resp  in  DATA_W  RAM load data, valid RAM_LAT cycles after issue.

Function
REQ-020 A request on port p SHALL be accepted when req_valid[p] & req_ready[p]; at most one req_ready bit is high per cycle.
REQ-021 req_ready SHALL be all-zero while ram_busy=1 or in reset.
REQ-022 Arbitration SHALL be round-robin: the grant goes to the first valid port at or after ptr; ptr SHALL become (granted+1) mod NUM_PORTS after each accept; ptr is unchanged when nothing is accepted.
REQ-023 req_ready is combinational from req_valid, ptr and ram_busy; no combinational path from ram_resp to req_ready.
REQ-024 An accepted LOAD/STORE SHALL drive ram_enable=1 with the granted port's fields in the same cycle (zero-cycle issue).
REQ-025 An accepted NOP or illegal op SHALL NOT drive ram_enable; it still occupies the tag pipeline.
REQ-026 Each accept SHALL push {valid, port id, err} into a RAM_LAT-deep tag shift register; one stage advances every cycle regardless of ram_busy.
REQ-027 When the tag exits, resp_valid[id] SHALL pulse for one cycle exactly RAM_LAT cycles after accept; resp_data=ram_resp for LOAD, zero for STORE/NOP/illegal.
REQ-028 resp_err[id]=1 only for op 3; resp_valid still pulses.
REQ-029 Throughput: one accept per cycle sustained while ram_busy=0; no bubbles under back-to-back requests.
REQ-030 Simultaneous response and new accept in one cycle SHALL both complete; the tag pipeline never stalls.
REQ-031 Request fields SHALL be held stable by the requester while req_valid=1 and req_ready=0.
REQ-032 When NUM_PORTS=1, ptr is constant 0 and arbitration degenerates to pass-through.

Reset
REQ-033 On RESET=0, asynchronously: ptr=0, all tag stages invalid, resp_valid=0, resp_err=0, ram_enable=0, req_ready=0.
REQ-034 Reset mid-operation SHALL drop all in-flight responses; no resp_valid pulse for pre-reset requests after release.
REQ-035 First accept is possible in the first cycle after RESET deasserts; resp_data is zero after reset until the first LOAD response.

Structure
REQ-036 Shared package mem_arb_pkg SHALL hold the memop enum (NOP/LOAD/STORE/ILLEGAL), the packed request struct {op, mask, addr, data}, and the tag struct.
REQ-037 Round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot grant).
REQ-038 Implementation target: 120-400 lines of RTL total.

Verification
REQ-039 Defaults, port1 LOAD addr 0x100, RAM returns 0xDEADBEEF -> ram_enable at accept, resp_valid=2'b10, resp_data=0xDEADBEEF after 1 cycle.
REQ-040 Both ports valid for 4 consecutive cycles, ptr=0 -> grants 0,1,0,1; responses alternate ports with latency RAM_LAT.
REQ-041 RAM_LAT=3, port0 STORE then port1 LOAD back-to-back -> resp_valid[0] at cycle 3 with data 0, resp_valid[1] at cycle 4 with RAM data.
REQ-042 ram_busy=1 for 2 cycles with both ports valid -> req_ready=0, ram_enable=0, ptr unchanged; in-flight responses still delivered on time.
REQ-043 Port0 op=3 -> ram_enable=0, resp_valid[0]=1 and resp_err[0]=1 after RAM_LAT cycles.
REQ-044 RESET asserted with 2 LOADs in flight (RAM_LAT=3) -> no resp_valid after release; ptr=0; next request served normally.
